// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit positions and hex glyph table.
package seg7_pkg;

  localparam int unsigned SEG_W  = 8;
  localparam int unsigned SEG_A  = 7;
  localparam int unsigned SEG_G  = 1;
  localparam int unsigned SEG_DP = 0;

  // Glyphs as {a,b,c,d,e,f,g}, entry 15 first.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to {a..g} segment pattern lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = HEX_SEG[hex];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner with shadow/display double buffering and guard blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned GUARD      = 2,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [SEG_W-1:0]        seg,
  output logic [NUM_DIGITS-1:0]   enable,
  output logic                    load_ack,
  output logic                    pending
);

  localparam int unsigned DIG_W = 4 * NUM_DIGITS;
  localparam int unsigned PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PS_W-1:0]       PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [PS_W-1:0]       GUARD_V  = PS_W'(GUARD);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] POL_EN   = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [SEG_W-1:0]      POL_SEG  = {SEG_W{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] ENA_RST  =
    ((GUARD == 0) ? NUM_DIGITS'(1) : '0) ^ POL_EN;

  logic [PS_W-1:0]       ps_q, ps_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  pending_q, pending_d;
  logic                  load_ack_q, load_ack_d;
  logic [DIG_W-1:0]      sh_dig_q, sh_dig_d, disp_dig_q, disp_dig_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d, disp_blank_q, disp_blank_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] enable_q, enable_d;
  logic                  tc, commit;
  logic [3:0]            nibble;
  logic [6:0]            glyph_c;

  // Scan timing, shadow capture and end-of-frame commit.
  always_comb begin
    tc           = (ps_q == PS_LAST);
    commit       = tc && (idx_q == IDX_LAST) && pending_q;
    ps_d         = tc ? '0 : ps_q + PS_W'(1);
    idx_d        = idx_q;
    sh_dig_d     = sh_dig_q;
    sh_dp_d      = sh_dp_q;
    sh_blank_d   = sh_blank_q;
    disp_dig_d   = disp_dig_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    if (tc) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    if (commit) begin
      disp_dig_d   = sh_dig_q;
      disp_dp_d    = sh_dp_q;
      disp_blank_d = sh_blank_q;
    end
    if (load) begin
      sh_dig_d   = digits_in;
      sh_dp_d    = dp_in;
      sh_blank_d = blank_in;
    end
    pending_d  = load | (pending_q & ~commit);
    load_ack_d = commit;
  end

  // Outputs are computed from next state so the registered pins line up with ps_q/idx_q.
  always_comb begin
    nibble = disp_dig_d[{idx_d, 2'b00} +: 4];
    seg_d  = '0;
    if (!disp_blank_d[idx_d]) begin
      seg_d[SEG_A:SEG_G] = glyph_c;
      seg_d[SEG_DP]      = disp_dp_d[idx_d];
    end
    seg_d    = seg_d ^ POL_SEG;
    enable_d = (ps_d < GUARD_V) ? '0 : (NUM_DIGITS'(1) << idx_d);
    enable_d = enable_d ^ POL_EN;
  end

  seg7_hex_decode u_decode (
    .hex   (nibble),
    .seg_c (glyph_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q         <= '0;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      load_ack_q   <= 1'b0;
      sh_dig_q     <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '1;
      disp_dig_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '1;
      seg_q        <= POL_SEG;
      enable_q     <= ENA_RST;
    end else begin
      ps_q         <= ps_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      load_ack_q   <= load_ack_d;
      sh_dig_q     <= sh_dig_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      disp_dig_q   <= disp_dig_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      seg_q        <= seg_d;
      enable_q     <= enable_d;
    end
  end

  assign seg      = seg_q;
  assign enable   = enable_q;
  assign load_ack = load_ack_q;
  assign pending  = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: active-high and active-low instances share stimulus.
module tb_seg7_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned TD = 4;
  localparam int unsigned GD = 1;

  typedef struct packed {
    logic [3:0] en;
    logic [7:0] seg;
    logic       ack;
    logic       pend;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [7:0]  seg0, seg1;
  logic [3:0]  en0, en1;
  logic        ack0, ack1, pend0, pend1;

  int n_checks = 0;
  int n_pass   = 0;

  // Bench-side model of what should be on the pins.
  int          m_k;
  logic        m_pend, m_ack;
  logic [15:0] m_sdig, m_ddig;
  logic [3:0]  m_sdp, m_ddp, m_sbl, m_dbl;
  exp_t        sb[$];
  logic [7:0]  hex_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  seg7_scan_driver #(.NUM_DIGITS(ND), .TICK_DIV(TD), .GUARD(GD), .ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .seg(seg0), .enable(en0), .load_ack(ack0), .pending(pend0)
  );

  seg7_scan_driver #(.NUM_DIGITS(ND), .TICK_DIV(TD), .GUARD(GD), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .seg(seg1), .enable(en1), .load_ack(ack1), .pending(pend1)
  );

  always #5 clk = ~clk;

  function automatic int cur_ps();
    return m_k % TD;
  endfunction

  function automatic int cur_idx();
    return (m_k / TD) % ND;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    int   ps, idx;
    ps    = cur_ps();
    idx   = cur_idx();
    e.en  = (ps < GD) ? 4'h0 : 4'(1 << idx);
    e.seg = m_dbl[idx] ? 8'h00 : (hex_tab[m_ddig[idx*4 +: 4]] | {7'b0, m_ddp[idx]});
    e.ack = m_ack;
    e.pend = m_pend;
    return e;
  endfunction

  task automatic model_reset();
    m_k = 0; m_pend = 1'b0; m_ack = 1'b0;
    m_sdig = '0; m_sdp = '0; m_sbl = 4'hF;
    m_ddig = '0; m_ddp = '0; m_dbl = 4'hF;
    sb.delete();
  endtask

  // Drive one cycle of stimulus from a falling edge, advance the model, queue the expectation.
  task automatic tick(input logic ld, input logic [15:0] d, input logic [3:0] dpv,
                      input logic [3:0] bl);
    logic commit;
    load = ld; digits_in = d; dp_in = dpv; blank_in = bl;
    commit = (cur_ps() == TD - 1) && (cur_idx() == ND - 1) && m_pend;
    @(posedge clk);
    m_ack = commit;
    if (commit) begin
      m_ddig = m_sdig; m_ddp = m_sdp; m_dbl = m_sbl;
    end
    if (ld) begin
      m_sdig = d; m_sdp = dpv; m_sbl = bl; m_pend = 1'b1;
    end else if (commit) begin
      m_pend = 1'b0;
    end
    m_k++;
    sb.push_back(expect_now());
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e, e1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({en0, seg0, ack0, pend0} !== 14'h0)
      $display("FAIL reset_hold dut0 got %h want %h", {en0, seg0, ack0, pend0}, 14'h0);
    else n_pass++;
    n_checks++;
    if ({en1, seg1, ack1, pend1} !== {4'hF, 8'hFF, 2'b00})
      $display("FAIL reset_hold dut1 got %h want %h", {en1, seg1, ack1, pend1},
               {4'hF, 8'hFF, 2'b00});
    else n_pass++;
    rst_n = 1'b1;
    model_reset();
    e = expect_now(); e1 = e; e1.en = ~e.en; e1.seg = ~e.seg;
    n_checks++;
    if ({en0, seg0, ack0, pend0} !== e)
      $display("FAIL reset_release dut0 got %h want %h", {en0, seg0, ack0, pend0}, e);
    else n_pass++;
    n_checks++;
    if ({en1, seg1, ack1, pend1} !== e1)
      $display("FAIL reset_release dut1 got %h want %h", {en1, seg1, ack1, pend1}, e1);
    else n_pass++;
  endtask

  task automatic test_idle_scan();
    exp_t e, e1;
    logic [3:0] seq [10] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h4};
    n_checks++;
    if (en0 !== seq[0]) $display("FAIL idle_enable k=0 got %h want %h", en0, seq[0]);
    else n_pass++;
    for (int i = 1; i < 10; i++) begin
      tick(1'b0, '0, '0, '0);
      e = sb.pop_front(); e1 = e; e1.en = ~e.en; e1.seg = ~e.seg;
      n_checks++;
      if ({en0, seg0, ack0, pend0} !== e)
        $display("FAIL idle_scan dut0 k=%0d got %h want %h", m_k, {en0, seg0, ack0, pend0}, e);
      else n_pass++;
      n_checks++;
      if ({en1, seg1, ack1, pend1} !== e1)
        $display("FAIL idle_scan dut1 k=%0d got %h want %h", m_k, {en1, seg1, ack1, pend1}, e1);
      else n_pass++;
      n_checks++;
      if (en0 !== seq[i] || seg0 !== 8'h00)
        $display("FAIL idle_enable k=%0d got en=%h seg=%h want en=%h seg=00", i, en0, seg0, seq[i]);
      else n_pass++;
    end
  endtask

  task automatic test_load();
    exp_t e, e1;
    int acks = 0;
    logic [7:0] lit [4] = '{8'h8E, 8'hFD, 8'hEE, 8'hF2};
    tick(1'b1, 16'h3A0F, 4'b0010, 4'b0000);
    n_checks++;
    if (pend0 !== 1'b1 || ack0 !== 1'b0)
      $display("FAIL load_pending got pend=%b ack=%b want pend=1 ack=0", pend0, ack0);
    else n_pass++;
    for (int i = 0; i < ND * TD + 2 + 1 && acks == 0; i++) begin
      if (i > 0) tick(1'b0, '0, '0, '0);
      e = sb.pop_front(); e1 = e; e1.en = ~e.en; e1.seg = ~e.seg;
      n_checks++;
      if ({en0, seg0, ack0, pend0} !== e)
        $display("FAIL load_wait dut0 k=%0d got %h want %h", m_k, {en0, seg0, ack0, pend0}, e);
      else n_pass++;
      n_checks++;
      if ({en1, seg1, ack1, pend1} !== e1)
        $display("FAIL load_wait dut1 k=%0d got %h want %h", m_k, {en1, seg1, ack1, pend1}, e1);
      else n_pass++;
      if (ack0 === 1'b1) acks++;
    end
    n_checks++;
    if (acks !== 1) $display("FAIL load_ack_seen got %0d want 1", acks);
    else n_pass++;
    for (int i = 0; i < ND * TD; i++) begin
      tick(1'b0, '0, '0, '0);
      e = sb.pop_front(); e1 = e; e1.en = ~e.en; e1.seg = ~e.seg;
      n_checks++;
      if ({en0, seg0, ack0, pend0} !== e || {en1, seg1, ack1, pend1} !== e1)
        $display("FAIL load_frame k=%0d got %h/%h want %h/%h", m_k,
                 {en0, seg0, ack0, pend0}, {en1, seg1, ack1, pend1}, e, e1);
      else n_pass++;
      if (cur_ps() >= GD) begin
        n_checks++;
        if (seg0 !== lit[cur_idx()] || ack0 !== 1'b0)
          $display("FAIL load_glyph digit=%0d got seg=%h ack=%b want seg=%h ack=0",
                   cur_idx(), seg0, ack0, lit[cur_idx()]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_double_load();
    exp_t e, e1;
    int acks = 0;
    for (int i = 0; i < 2 * ND * TD; i++) begin
      if (i == 1)      tick(1'b1, 16'h1111, 4'b0000, 4'b0000);
      else if (i == 3) tick(1'b1, 16'h2222, 4'b0000, 4'b0000);
      else             tick(1'b0, '0, '0, '0);
      e = sb.pop_front(); e1 = e; e1.en = ~e.en; e1.seg = ~e.seg;
      n_checks++;
      if ({en0, seg0, ack0, pend0} !== e || {en1, seg1, ack1, pend1} !== e1)
        $display("FAIL double_load k=%0d got %h/%h want %h/%h", m_k,
                 {en0, seg0, ack0, pend0}, {en1, seg1, ack1, pend1}, e, e1);
      else n_pass++;
      if (ack0 === 1'b1) acks++;
    end
    n_checks++;
    if (acks !== 1 || pend0 !== 1'b0 || seg0 !== 8'hDA)
      $display("FAIL double_load_summary got acks=%0d pend=%b seg=%h want acks=1 pend=0 seg=da",
               acks, pend0, seg0);
    else n_pass++;
  endtask

  task automatic test_coincident();
    exp_t e, e1;
    int acks = 0;
    tick(1'b1, 16'h5555, 4'b0000, 4'b0000);
    void'(sb.pop_front());
    for (int i = 0; i < 2 * ND * TD && !(cur_ps() == TD - 1 && cur_idx() == ND - 1); i++) begin
      tick(1'b0, '0, '0, '0);
      void'(sb.pop_front());
    end
    tick(1'b1, 16'h7777, 4'b0000, 4'b0000);
    e = sb.pop_front();
    n_checks++;
    if (ack0 !== 1'b1 || pend0 !== 1'b1 || {en0, seg0, ack0, pend0} !== e)
      $display("FAIL coincident_commit got ack=%b pend=%b seg=%h want ack=1 pend=1 seg=b6",
               ack0, pend0, seg0);
    else n_pass++;
    for (int i = 0; i < ND * TD; i++) begin
      tick(1'b0, '0, '0, '0);
      e = sb.pop_front(); e1 = e; e1.en = ~e.en; e1.seg = ~e.seg;
      n_checks++;
      if ({en0, seg0, ack0, pend0} !== e || {en1, seg1, ack1, pend1} !== e1)
        $display("FAIL coincident_frame k=%0d got %h/%h want %h/%h", m_k,
                 {en0, seg0, ack0, pend0}, {en1, seg1, ack1, pend1}, e, e1);
      else n_pass++;
      if (ack0 === 1'b1) acks++;
    end
    n_checks++;
    if (acks !== 1 || pend0 !== 1'b0 || seg0 !== 8'hE0)
      $display("FAIL coincident_second got acks=%0d pend=%b seg=%h want acks=1 pend=0 seg=e0",
               acks, pend0, seg0);
    else n_pass++;
  endtask

  task automatic test_blank();
    exp_t e, e1;
    int slot2 = 0;
    tick(1'b1, 16'h8888, 4'b1111, 4'b0100);
    void'(sb.pop_front());
    for (int i = 0; i < 2 * ND * TD; i++) begin
      tick(1'b0, '0, '0, '0);
      e = sb.pop_front(); e1 = e; e1.en = ~e.en; e1.seg = ~e.seg;
      n_checks++;
      if ({en0, seg0, ack0, pend0} !== e || {en1, seg1, ack1, pend1} !== e1)
        $display("FAIL blank_scan k=%0d got %h/%h want %h/%h", m_k,
                 {en0, seg0, ack0, pend0}, {en1, seg1, ack1, pend1}, e, e1);
      else n_pass++;
      if (m_dbl == 4'b0100 && cur_idx() == 2 && cur_ps() >= GD) begin
        slot2++;
        n_checks++;
        if (en0 !== 4'b0100 || seg0 !== 8'h00 || en1 !== 4'b1011 || seg1 !== 8'hFF)
          $display("FAIL blank_slot got en=%h seg=%h en_n=%h seg_n=%h want 4 00 b ff",
                   en0, seg0, en1, seg1);
        else n_pass++;
      end
    end
    n_checks++;
    if (slot2 == 0) $display("FAIL blank_slot_reached got 0 want >0");
    else n_pass++;
  endtask

  task automatic test_reset_pending();
    exp_t e, e1;
    int acks = 0;
    tick(1'b0, '0, '0, '0);
    tick(1'b1, 16'h9999, 4'b0101, 4'b0000);
    tick(1'b0, '0, '0, '0);
    sb.delete();
    n_checks++;
    if (pend0 !== 1'b1) $display("FAIL rst_pend_setup got pend=%b want 1", pend0);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({en0, seg0, ack0, pend0} !== 14'h0 || {en1, seg1, ack1, pend1} !== {4'hF, 8'hFF, 2'b00})
      $display("FAIL async_reset got %h/%h want 0000/3ffc", {en0, seg0, ack0, pend0},
               {en1, seg1, ack1, pend1});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * ND * TD; i++) begin
      tick(1'b0, '0, '0, '0);
      e = sb.pop_front(); e1 = e; e1.en = ~e.en; e1.seg = ~e.seg;
      n_checks++;
      if ({en0, seg0, ack0, pend0} !== e || {en1, seg1, ack1, pend1} !== e1)
        $display("FAIL rst_after k=%0d got %h/%h want %h/%h", m_k,
                 {en0, seg0, ack0, pend0}, {en1, seg1, ack1, pend1}, e, e1);
      else n_pass++;
      if (ack0 === 1'b1 || ack1 === 1'b1) acks++;
    end
    n_checks++;
    if (acks !== 0) $display("FAIL rst_no_ack got %0d acks want 0", acks);
    else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_scan();
    test_load();
    test_double_load();
    test_coincident();
    test_blank();
    test_reset_pending();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
